// File: rtl/nes_tetris_soc_key_pio.sv
// Avalon-MM input PIO for board keys/switches: per-bit synchroniser, debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module nes_tetris_soc_key_pio #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_clr;
    logic             bus_wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign raw          = sync_q[SYNC_STAGES-1];
    assign bus_wr       = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_VEC;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= IDLE_VEC;
            for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (raw[b] == data_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    data_q[b] <= raw[b];
                    cnt_q[b]  <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = data_prev_q & ~data_q;
            1:       edge_hit = ~data_prev_q & data_q;
            default: edge_hit = data_prev_q ^ data_q;
        endcase
    end

    assign edge_clr = (bus_wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    // A new capture in the same cycle as a clear survives: set is ORed in last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_prev_q <= IDLE_VEC;
            edge_q      <= '0;
            mask_q      <= '0;
        end else begin
            data_prev_q <= data_q;
            edge_q      <= (edge_q & ~edge_clr) | edge_hit;
            if (bus_wr && address == 2'd1) mask_q <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = data_q;
            2'd1: rd_mux[WIDTH-1:0] = mask_q;
            2'd2: rd_mux[WIDTH-1:0] = edge_q;
            2'd3: rd_mux[WIDTH-1:0] = raw;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = |(edge_q & mask_q);

endmodule
